// File: rtl/tq_dct4_pkg.sv
// Shared definitions for the 4-point forward DCT row engine: FSM state
// encoding, multiplier datapath widths and the DCT coefficient constants.
package tq_dct4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Operand width at the shared constant multiplier and its product width.
    localparam int MUL_W  = 20;
    localparam int PROD_W = 27;

    // 4-point DCT basis constants (even rows use 64, odd rows use 83/36).
    localparam int COEF_64 = 64;
    localparam int COEF_83 = 83;
    localparam int COEF_36 = 36;

endpackage

// File: rtl/tq_dct4_seq_spiral_0.sv
// spiral_0: multiplierless constant multiplier producing 36*x and 83*x from
// a single signed operand using shift-and-add networks.
module spiral_0
    import tq_dct4_pkg::*;
(
    input  logic signed [MUL_W-1:0]  i_data,
    output logic signed [PROD_W-1:0] o_data_36,
    output logic signed [PROD_W-1:0] o_data_83
);

    logic signed [PROD_W-1:0] x;

    assign x = PROD_W'(i_data);

    // 36 = 32 + 4
    assign o_data_36 = (x <<< 5) + (x <<< 2);
    // 83 = 64 + 16 + 2 + 1
    assign o_data_83 = (x <<< 6) + (x <<< 4) + (x <<< 1) + x;

endmodule

// File: rtl/tq_dct4_seq.sv
// tq_dct4_seq: sequenced 1-D 4-point forward DCT row engine.
// Even outputs come from shift/add of the registered butterflies; both odd
// outputs share one spiral_0 instance, fed O0 in MUL0 and O1 in MUL1.
// Optional build macro: TQ_DCT4_ROUND_EN adds (v + 2^(SHIFT-1)) >>> SHIFT
// rounding on every output in the MUL1 cycle.
module tq_dct4_seq
    import tq_dct4_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 28,
    parameter int SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [IN_W-1:0]  i_x0,
    input  logic signed [IN_W-1:0]  i_x1,
    input  logic signed [IN_W-1:0]  i_x2,
    input  logic signed [IN_W-1:0]  i_x3,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [OUT_W-1:0] o_y0,
    output logic signed [OUT_W-1:0] o_y1,
    output logic signed [OUT_W-1:0] o_y2,
    output logic signed [OUT_W-1:0] o_y3,
    output logic [1:0]              o_row,
    output logic                    o_last
);

    localparam int BF_W    = IN_W + 1;
    localparam int EVEN_SH = $clog2(COEF_64);

    state_e state_q, state_d;
    logic   accept;

    logic signed [BF_W-1:0]   e0_q, e1_q, o0_q, o1_q;
    logic signed [MUL_W-1:0]  mul_in;
    logic signed [PROD_W-1:0] m36, m83;
    logic signed [PROD_W-1:0] p36_q, p83_q;

    logic signed [OUT_W-1:0]  y0_full, y1_full, y2_full, y3_full;
    logic signed [OUT_W-1:0]  y0_d, y1_d, y2_d, y3_d;
    logic signed [OUT_W-1:0]  y0_q, y1_q, y2_q, y3_q;
    logic [1:0]               row_q;

    assign accept = i_valid & o_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; o_ready depends only on state and i_ready.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_d = MUL0;
            end
            MUL0: state_d = MUL1;
            MUL1: state_d = OUT;
            OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    o_ready = 1'b1;
                    state_d = i_valid ? MUL0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Butterflies captured on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath flops are reset too, so outputs read 0 after reset.
            e0_q <= '0;
            e1_q <= '0;
            o0_q <= '0;
            o1_q <= '0;
        end else if (accept) begin
            e0_q <= BF_W'(i_x0) + BF_W'(i_x3);
            e1_q <= BF_W'(i_x1) + BF_W'(i_x2);
            o0_q <= BF_W'(i_x0) - BF_W'(i_x3);
            o1_q <= BF_W'(i_x1) - BF_W'(i_x2);
        end
    end

    // Shared multiplier operand: O0 during MUL0, O1 during MUL1.
    assign mul_in = (state_q == MUL1) ? MUL_W'(o1_q) : MUL_W'(o0_q);

    spiral_0 u_spiral (
        .i_data    (mul_in),
        .o_data_36 (m36),
        .o_data_83 (m83)
    );

    // Hold the O0 products for use alongside the O1 products in MUL1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p36_q <= '0;
            p83_q <= '0;
        end else if (state_q == MUL0) begin
            p36_q <= m36;
            p83_q <= m83;
        end
    end

`ifdef TQ_DCT4_ROUND_EN
    function automatic logic signed [OUT_W-1:0] round_shift(input logic signed [OUT_W-1:0] v);
        return (v + (OUT_W'(1) <<< (SHIFT - 1))) >>> SHIFT;
    endfunction
`else
    // Full-precision build: SHIFT has no effect.
    logic unused_shift;
    assign unused_shift = |SHIFT;
`endif

    // Output coefficients at OUT_W, optionally rounded, formed during MUL1.
    always_comb begin
        y0_full = (OUT_W'(e0_q) + OUT_W'(e1_q)) <<< EVEN_SH;
        y2_full = (OUT_W'(e0_q) - OUT_W'(e1_q)) <<< EVEN_SH;
        y1_full = OUT_W'(p83_q) + OUT_W'(m36);
        y3_full = OUT_W'(p36_q) - OUT_W'(m83);
`ifdef TQ_DCT4_ROUND_EN
        y0_d = round_shift(y0_full);
        y1_d = round_shift(y1_full);
        y2_d = round_shift(y2_full);
        y3_d = round_shift(y3_full);
`else
        y0_d = y0_full;
        y1_d = y1_full;
        y2_d = y2_full;
        y3_d = y3_full;
`endif
    end

    // Output registers, loaded once per row and held through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
            y3_q <= '0;
        end else if (state_q == MUL1) begin
            y0_q <= y0_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
            y3_q <= y3_d;
        end
    end

    // Row index within the 4x4 block, advanced on each output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 2'd0;
        end else if (o_valid && i_ready) begin
            row_q <= row_q + 2'd1;
        end
    end

    assign o_y0   = y0_q;
    assign o_y1   = y1_q;
    assign o_y2   = y2_q;
    assign o_y3   = y3_q;
    assign o_row  = row_q;
    assign o_last = o_valid & (row_q == 2'd3);

endmodule

// File: tb/tb_tq_dct4_seq.sv
// Self-checking bench for tq_dct4_seq: directed basis/extreme rows,
// backpressure, back-to-back streaming, random rows with random i_ready,
// and reset during MUL1. Expected rows come from a 4x4 DCT matrix product.
module tb_tq_dct4_seq;
    import tq_dct4_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 28;
`ifdef TQ_DCT4_ROUND_EN
    localparam int SHIFT = 2;
`else
    localparam int SHIFT = 1;
`endif

    typedef struct {
        longint y [4];
    } row_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    i_valid;
    logic                    o_ready;
    logic signed [IN_W-1:0]  i_x0, i_x1, i_x2, i_x3;
    logic                    o_valid;
    logic                    i_ready;
    logic signed [OUT_W-1:0] o_y0, o_y1, o_y2, o_y3;
    logic [1:0]              o_row;
    logic                    o_last;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     exp_row  = 0;
    bit     ready_lvl;
    bit     ready_rand;
    row_t   exp_q [$];
    int     hs_q [$];
    longint last_y [4];

    tq_dct4_seq #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_x0    (i_x0),
        .i_x1    (i_x1),
        .i_x2    (i_x2),
        .i_x3    (i_x3),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_y0    (o_y0),
        .o_y1    (o_y1),
        .o_y2    (o_y2),
        .o_y3    (o_y3),
        .o_row   (o_row),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint rnd(input longint v);
`ifdef TQ_DCT4_ROUND_EN
        return (v + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`else
        return v;
`endif
    endfunction

    // Reference: y = C * x with the 4-point DCT integer basis matrix.
    function automatic row_t ref_row(input longint x0, x1, x2, x3);
        longint c [4][4];
        longint x [4];
        longint acc;
        row_t   r;
        c = '{'{COEF_64,  COEF_64,  COEF_64,  COEF_64},
              '{COEF_83,  COEF_36, -COEF_36, -COEF_83},
              '{COEF_64, -COEF_64, -COEF_64,  COEF_64},
              '{COEF_36, -COEF_83,  COEF_83, -COEF_36}};
        x = '{x0, x1, x2, x3};
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int n = 0; n < 4; n++) acc += c[k][n] * x[n];
            r.y[k] = rnd(acc);
        end
        return r;
    endfunction

    function automatic longint rand_s16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return longint'(t);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a row; returns just after the edge that accepts it.
    task automatic send(input longint a, b, c, d);
        int n = 0;
        i_x0 = IN_W'(a);
        i_x1 = IN_W'(b);
        i_x2 = IN_W'(c);
        i_x3 = IN_W'(d);
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) check("accept_timeout", o_ready, 1);
        else exp_q.push_back(ref_row(a, b, c, d));
        sync();
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic clock_count();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #2;
            i_ready = ready_rand ? ($urandom_range(1, 0) != 0) : ready_lvl;
        end
    endtask

    // Scoreboard on output handshakes plus hold-stability under backpressure.
    task automatic monitor();
        logic [4*OUT_W+2:0] prev_v, cur_v;
        bit     stall = 1'b0;
        row_t   e;
        longint act [4];
        forever begin
            @(negedge clk);
            cur_v = {o_valid, o_row, o_y0, o_y1, o_y2, o_y3};
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) check("hold_outputs", longint'(cur_v == prev_v), 1);
                if (o_valid && i_ready) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_row", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        act[0] = o_y0;
                        act[1] = o_y1;
                        act[2] = o_y2;
                        act[3] = o_y3;
                        for (int k = 0; k < 4; k++) check($sformatf("y%0d", k), act[k], e.y[k]);
                        check("o_row", o_row, exp_row);
                        check("o_last", o_last, longint'(exp_row == 3));
                        exp_row = (exp_row + 1) % 4;
                        last_y = act;
                    end
                end
                stall = o_valid && !i_ready;
                prev_v = cur_v;
            end
        end
    endtask

    initial begin
        int c0;
        int n;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_x0       = '0;
        i_x1       = '0;
        i_x2       = '0;
        i_x3       = '0;
        i_ready    = 1'b1;
        ready_lvl  = 1'b1;
        ready_rand = 1'b0;
        fork
            clock_count();
            ready_gen();
            monitor();
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_y0", o_y0, 0);
        check("rst_o_y3", o_y3, 0);
        check("rst_o_row", o_row, 0);
        check("rst_o_last", o_last, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_ready", o_ready, 1);

        // Impulse: result visible three edges after the row is presented in IDLE.
        sync();
        c0 = cyc;
        send(1, 0, 0, 0);
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", cyc - c0, 3);
        wait_drain();
`ifdef TQ_DCT4_ROUND_EN
        check("imp_y0", last_y[0], 16);
        check("imp_y1", last_y[1], 21);
        check("imp_y2", last_y[2], 16);
        check("imp_y3", last_y[3], 9);
`else
        check("imp_y0", last_y[0], 64);
        check("imp_y1", last_y[1], 83);
        check("imp_y2", last_y[2], 64);
        check("imp_y3", last_y[3], 36);
`endif

        // Second basis vector and full-scale extreme row.
        sync();
        send(0, 1, 0, 0);
        wait_drain();
        sync();
        send(32767, 32767, -32768, -32768);
        wait_drain();
`ifndef TQ_DCT4_ROUND_EN
        check("ext_y0", last_y[0], -128);
        check("ext_y1", last_y[1], 7798665);
        check("ext_y2", last_y[2], 0);
        check("ext_y3", last_y[3], -3080145);
`endif

        // Backpressure: five stalled cycles in OUT.
        ready_lvl = 1'b0;
        sync();
        sync();
        send(rand_s16(), rand_s16(), rand_s16(), rand_s16());
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_o_valid", o_valid, 1);
            check("bp_o_ready", o_ready, 0);
        end
        ready_lvl = 1'b1;
        wait_drain();

        // Back-to-back stream: output handshakes three cycles apart.
        hs_q.delete();
        sync();
        for (int r = 0; r < 8; r++) send(rand_s16(), rand_s16(), rand_s16(), rand_s16());
        wait_drain();
        check("stream_rows", hs_q.size(), 8);
        for (int i = 1; i < hs_q.size(); i++) check("stream_spacing", hs_q[i] - hs_q[i-1], 3);

        // Random rows with random downstream readiness.
        ready_rand = 1'b1;
        sync();
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(3, 0) == 0) send(32767, -32768, 32767, -32768);
            else send(rand_s16(), rand_s16(), rand_s16(), rand_s16());
        end
        wait_drain();
        ready_rand = 1'b0;

        // Reset while the row is in MUL1: everything clears at once.
        sync();
        send(rand_s16(), rand_s16(), rand_s16(), rand_s16());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_o_valid", o_valid, 0);
        check("mrst_o_y0", o_y0, 0);
        check("mrst_o_y1", o_y1, 0);
        check("mrst_o_y2", o_y2, 0);
        check("mrst_o_y3", o_y3, 0);
        check("mrst_o_row", o_row, 0);
        check("mrst_o_last", o_last, 0);
        exp_q.delete();
        exp_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        send(-1234, 567, 8901, -23456);
        wait_drain();
        check("post_rst_rows", exp_row, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
